multicycle_controller: RTL and testbench

//  Multi-cycle sequencer for the RV32I core datapath: FETCH/DECODE/EXEC/MEM/WB FSM.

---
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle RV32I datapath
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   o_imem_req / i_imem_ack         instruction fetch handshake
//   o_ir_wr_enable                  latch instruction register on fetch ack
//   i_is_load, i_is_store,
//   i_is_branch, i_is_jump,
//   i_reg_wr_enable_in, i_is_illegal  decoded OpInfo flags, sampled DECODE..WB
//   o_dmem_req / o_dmem_wr_enable /
//   i_dmem_ack                      data memory handshake
//   o_pc_wr_enable, o_rf_wr_enable  PC commit and register-file write strobes
//   o_halted, o_timeout_err         HALT state and sticky handshake-timeout flag
//   o_state_out                     current state encoding
//   o_cycle_count, o_retire_count   performance counters (MULTICYCLE_CTRL_PERF_EN)
module multicycle_controller #(
    parameter logic [7:0] MAX_WAIT       = 8'd255,
    parameter int         PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      o_imem_req,
    input  logic                      i_imem_ack,
    output logic                      o_ir_wr_enable,
    input  logic                      i_is_load,
    input  logic                      i_is_store,
    input  logic                      i_is_branch,
    input  logic                      i_is_jump,
    input  logic                      i_reg_wr_enable_in,
    input  logic                      i_is_illegal,
    output logic                      o_dmem_req,
    output logic                      o_dmem_wr_enable,
    input  logic                      i_dmem_ack,
    output logic                      o_pc_wr_enable,
    output logic                      o_rf_wr_enable,
    output logic                      o_halted,
    output logic                      o_timeout_err,
    output logic [2:0]                o_state_out,
    output logic [PERF_CNT_WIDTH-1:0] o_cycle_count,
    output logic [PERF_CNT_WIDTH-1:0] o_retire_count
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       r_timeout_err;
    logic       w_imem_req, w_ir_wr, w_dmem_req, w_dmem_wr, w_pc_wr, w_rf_wr, w_timeout;
    logic       w_last;
    logic       w_unused;

    // Branch and jump need no sequencing of their own; the datapath resolves the target.
    assign w_unused = ^{i_is_branch, i_is_jump};
    assign w_last   = r_wait_cnt == MAX_WAIT - 8'd1;

    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_ir_wr    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_wr  = 1'b0;
        w_pc_wr    = 1'b0;
        w_rf_wr    = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                // An ack on the final allowed cycle still completes normally.
                if (i_imem_ack) begin
                    w_ir_wr = 1'b1;
                    w_next  = DECODE;
                end else if (w_last) begin
                    w_timeout = 1'b1;
                    w_next    = HALT;
                end
            end
            DECODE: w_next = (i_is_illegal || (i_is_load && i_is_store)) ? HALT : EXEC;
            EXEC: begin
                if (i_is_load || i_is_store) begin
                    w_next = MEM;
                end else if (i_reg_wr_enable_in) begin
                    w_next = WB;
                end else begin
                    w_pc_wr = 1'b1;
                    w_next  = FETCH;
                end
            end
            MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_wr  = i_is_store;
                if (i_dmem_ack) begin
                    w_pc_wr = !i_is_load;
                    w_next  = i_is_load ? WB : FETCH;
                end else if (w_last) begin
                    w_timeout = 1'b1;
                    w_next    = HALT;
                end
            end
            WB: begin
                w_rf_wr = 1'b1;
                w_pc_wr = 1'b1;
                w_next  = FETCH;
            end
            HALT:    w_next = HALT;
            default: w_next = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            // Counts only while a request stays pending; any state change clears it.
            r_wait_cnt    <= ((w_imem_req || w_dmem_req) && w_next == r_state) ? r_wait_cnt + 8'd1 : 8'd0;
            r_timeout_err <= r_timeout_err | w_timeout;
        end
    end

    // Strobes are forced low during reset so a mid-instruction reset commits nothing.
    assign o_imem_req       = w_imem_req & ~rst;
    assign o_ir_wr_enable   = w_ir_wr & ~rst;
    assign o_dmem_req       = w_dmem_req & ~rst;
    assign o_dmem_wr_enable = w_dmem_wr & ~rst;
    assign o_pc_wr_enable   = w_pc_wr & ~rst;
    assign o_rf_wr_enable   = w_rf_wr & ~rst;
    assign o_halted         = r_state == HALT;
    assign o_timeout_err    = r_timeout_err;
    assign o_state_out      = r_state;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] r_cycle_count, r_retire_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else begin
            if (r_state != HALT) r_cycle_count <= r_cycle_count + PERF_CNT_WIDTH'(1);
            if (w_pc_wr) r_retire_count <= r_retire_count + PERF_CNT_WIDTH'(1);
        end
    end

    assign o_cycle_count  = r_cycle_count;
    assign o_retire_count = r_retire_count;
`else
    assign o_cycle_count  = '0;
    assign o_retire_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller
module tb_multicycle_controller;
`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
    logic        reg_wr = 1'b0, is_illegal = 1'b0;
    logic        o_imem_req, o_ir_wr_enable, o_dmem_req, o_dmem_wr_enable;
    logic        o_pc_wr_enable, o_rf_wr_enable, o_halted, o_timeout_err;
    logic [2:0]  o_state_out;
    logic [31:0] o_cycle_count, o_retire_count;

    multicycle_controller #(.MAX_WAIT(8'd4), .PERF_CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .o_imem_req(o_imem_req), .i_imem_ack(imem_ack), .o_ir_wr_enable(o_ir_wr_enable),
        .i_is_load(is_load), .i_is_store(is_store), .i_is_branch(is_branch), .i_is_jump(is_jump),
        .i_reg_wr_enable_in(reg_wr), .i_is_illegal(is_illegal),
        .o_dmem_req(o_dmem_req), .o_dmem_wr_enable(o_dmem_wr_enable), .i_dmem_ack(dmem_ack),
        .o_pc_wr_enable(o_pc_wr_enable), .o_rf_wr_enable(o_rf_wr_enable),
        .o_halted(o_halted), .o_timeout_err(o_timeout_err), .o_state_out(o_state_out),
        .o_cycle_count(o_cycle_count), .o_retire_count(o_retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] trace;
        int          cyc, ireq, irw, dreq, dwr, rfw, pcw;
        logic        hlt, terr;
        int          ret;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, events = 0;
    int          iw = 0, dw = 0, n_ret = 0;
    logic        spur = 1'b0;
    logic [23:0] m_tr;
    int          m_cyc, m_ireq, m_irw, m_dreq, m_dwr, m_rfw, m_pcw, m_tot;
    logic        m_ph;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] tr(input string s);
        logic [23:0] t = '0;
        for (int i = 0; i < s.len(); i++) t = {t[20:0], 3'(s[i] - "0")};
        return t;
    endfunction

    // Memory responders: ack after a programmed number of wait cycles while a request is up.
    initial begin
        int ic = 0;
        forever begin
            @(posedge clk);
            #2;
            if (o_imem_req) begin
                imem_ack = (ic == iw);
                ic = imem_ack ? 0 : ic + 1;
            end else begin
                imem_ack = 1'b0;
                ic = 0;
            end
        end
    end

    initial begin
        int dc = 0;
        forever begin
            @(posedge clk);
            #2;
            if (o_dmem_req) begin
                dmem_ack = (dc == dw);
                dc = dmem_ack ? 0 : dc + 1;
            end else begin
                dmem_ack = spur;
                dc = 0;
            end
        end
    end

    task automatic clear_acc();
        m_tr = '0; m_cyc = 0; m_ireq = 0; m_irw = 0; m_dreq = 0; m_dwr = 0; m_rfw = 0; m_pcw = 0;
    endtask

    task automatic judge();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got event in state %0d expected none", o_state_out);
        end else begin
            e = sb.pop_front();
            chk("state_trace", m_tr, e.trace);
            chk("cycles", m_cyc, e.cyc);
            chk("imem_req_cycles", m_ireq, e.ireq);
            chk("ir_wr_count", m_irw, e.irw);
            chk("dmem_req_cycles", m_dreq, e.dreq);
            chk("dmem_wr_cycles", m_dwr, e.dwr);
            chk("rf_wr_count", m_rfw, e.rfw);
            chk("pc_wr_count", m_pcw, e.pcw);
            chk("halted", o_halted, e.hlt);
            chk("timeout_err", o_timeout_err, e.terr);
            chk("retire_count", o_retire_count, e.ret);
            chk("cycle_count", o_cycle_count, PERF ? m_tot : 0);
        end
        clear_acc();
        events++;
    endtask

    // Monitor: accumulates per-instruction activity, judges on PC commit or HALT entry.
    initial begin
        clear_acc();
        m_tot = 0;
        m_ph = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                clear_acc();
                m_tot = 0;
                m_ph = 1'b0;
            end else if (o_halted) begin
                chk("halt_strobes", {o_imem_req, o_ir_wr_enable, o_dmem_req, o_dmem_wr_enable,
                                     o_pc_wr_enable, o_rf_wr_enable}, 0);
                if (!m_ph) judge();
                m_ph = 1'b1;
            end else begin
                m_tr = {m_tr[20:0], o_state_out};
                m_cyc++;
                m_ireq += int'(o_imem_req);
                m_irw  += int'(o_ir_wr_enable);
                m_dreq += int'(o_dmem_req);
                m_dwr  += int'(o_dmem_wr_enable);
                m_rfw  += int'(o_rf_wr_enable);
                m_pcw  += int'(o_pc_wr_enable);
                if (o_pc_wr_enable) judge();
                m_tot++;
            end
        end
    end

    task automatic wait_event();
        int ev0 = events;
        int k = 0;
        while (events == ev0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (events == ev0) chk("event_timeout", 0, 1);
    endtask

    // Called at posedge+1 with the DUT in FETCH; flags are held for the whole instruction.
    task automatic issue(input logic [5:0] f, input int iwv, input int dwv, input logic spv,
                         input string trs, input int cyc, input int ireq, input int irw,
                         input int dreq, input int dwr, input int rfw, input int pcw,
                         input logic hlt, input logic terr);
        exp_t e;
        {is_load, is_store, is_branch, is_jump, reg_wr, is_illegal} = f;
        iw = iwv;
        dw = dwv;
        spur = spv;
        e.trace = tr(trs); e.cyc = cyc; e.ireq = ireq; e.irw = irw; e.dreq = dreq; e.dwr = dwr;
        e.rfw = rfw; e.pcw = pcw; e.hlt = hlt; e.terr = terr; e.ret = PERF ? n_ret : 0;
        sb.push_back(e);
        if (!hlt) n_ret++;
        wait_event();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        spur = 1'b0;
        @(negedge clk);
        chk("rst_strobes", {o_imem_req, o_ir_wr_enable, o_dmem_req, o_dmem_wr_enable,
                            o_pc_wr_enable, o_rf_wr_enable}, 0);
        @(posedge clk);
        #1;
        chk("rst_state", o_state_out, 0);
        chk("rst_timeout_err", o_timeout_err, 0);
        chk("rst_counters", {o_cycle_count, o_retire_count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_ret = 0;
    endtask

    localparam logic [5:0] F_ALU = 6'b000010, F_LD = 6'b100010, F_ST = 6'b010000;
    localparam logic [5:0] F_BR = 6'b001000, F_JP = 6'b000110, F_ILL = 6'b000001, F_LS = 6'b110000;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        reset_dut();
        issue(F_ALU, 0, 0, 1'b0, "0124", 4, 1, 1, 0, 0, 1, 1, 1'b0, 1'b0);
        issue(F_LD, 0, 3, 1'b0, "01233334", 8, 1, 1, 4, 0, 1, 1, 1'b0, 1'b0);
        issue(F_ST, 0, 0, 1'b0, "0123", 4, 1, 1, 1, 1, 0, 1, 1'b0, 1'b0);
        issue(F_BR, 0, 0, 1'b0, "012", 3, 1, 1, 0, 0, 0, 1, 1'b0, 1'b0);
        issue(F_JP, 2, 0, 1'b1, "000124", 6, 3, 1, 0, 0, 1, 1, 1'b0, 1'b0);
        issue(F_ALU, 3, 0, 1'b0, "0000124", 7, 4, 1, 0, 0, 1, 1, 1'b0, 1'b0);
        issue(F_LD, 1, 1, 1'b0, "0012334", 7, 2, 1, 2, 0, 1, 1, 1'b0, 1'b0);
        issue(F_ALU, 1000, 0, 1'b0, "0000", 4, 4, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset_dut();
        issue(F_ILL, 0, 0, 1'b0, "01", 2, 1, 1, 0, 0, 0, 0, 1'b1, 1'b0);
        reset_dut();
        issue(F_LS, 0, 0, 1'b0, "01", 2, 1, 1, 0, 0, 0, 0, 1'b1, 1'b0);
        reset_dut();
        issue(F_ST, 0, 1000, 1'b0, "0123333", 7, 1, 1, 4, 4, 0, 0, 1'b1, 1'b1);
        reset_dut();
        issue(F_ALU, 0, 0, 1'b0, "0124", 4, 1, 1, 0, 0, 1, 1, 1'b0, 1'b0);
        begin
            int k = 0;
            {is_load, is_store, is_branch, is_jump, reg_wr, is_illegal} = F_LD;
            iw = 0;
            dw = 5;
            while (o_state_out != 3'd3 && k < 50) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("reach_mem", o_state_out, 3);
            rst = 1'b1;
            @(negedge clk);
            chk("midmem_rst_strobes", {o_imem_req, o_dmem_req, o_pc_wr_enable, o_rf_wr_enable}, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            n_ret = 0;
            chk("midmem_state", o_state_out, 0);
            chk("midmem_counters", {o_cycle_count, o_retire_count}, 0);
        end
        issue(F_ALU, 0, 0, 1'b0, "0124", 4, 1, 1, 0, 0, 1, 1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
